// File: rtl/stack_pkg.sv
// Shared constants and helpers for the dual-mode stack/queue buffer.
package stack_pkg;

  localparam logic MODE_LIFO = 1'b0;
  localparam logic MODE_FIFO = 1'b1;

  // Occupancy must hold 0..depth inclusive, hence one extra bit.
  function automatic int count_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/stack_regfile.sv
// Storage array: one synchronous write port, one combinational read port, no reset.
module stack_regfile #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/stack_queue.sv
// Register-file buffer running as a LIFO stack or FIFO queue, with occupancy
// count, simultaneous push/pop and sticky overflow/underflow flags.
module stack_queue
  import stack_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                                 clk,
  input  logic                                 clr_n,
  input  logic                                 mode,
  input  logic                                 push_en,
  input  logic                                 pop_en,
  input  logic [WIDTH-1:0]                     push,
  input  logic                                 err_clr,
  output logic [WIDTH-1:0]                     peek,
  output logic [count_width(DEPTH_LOG2)-1:0]   count,
  output logic                                 full,
  output logic                                 not_empty,
  output logic                                 active_mode,
  output logic                                 ovf,
  output logic                                 unf
);

  localparam int CW = count_width(DEPTH_LOG2);
  localparam logic [CW-1:0]         CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]         CNT_DEPTH = CW'(2 ** DEPTH_LOG2);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r, wr_ptr_nxt_s, rd_ptr_nxt_s;
  logic [DEPTH_LOG2-1:0] top_ptr_s, waddr_s, raddr_s;
  logic [CW-1:0]         count_r, count_nxt_s;
  logic                  mode_r, ovf_r, unf_r;
  logic                  we_s, ovf_set_s, unf_set_s, empty_s, full_s;
  logic [WIDTH-1:0]      rdata_s;

  assign top_ptr_s = wr_ptr_r - PTR_ONE;
  assign empty_s   = (count_r == {CW{1'b0}});
  assign full_s    = (count_r == CNT_DEPTH);
  assign raddr_s   = (mode_r == MODE_FIFO) ? rd_ptr_r : top_ptr_s;

  assign peek        = empty_s ? {WIDTH{1'b0}} : rdata_s;
  assign count       = count_r;
  assign full        = full_s;
  assign not_empty   = ~empty_s;
  assign active_mode = mode_r;
  assign ovf         = ovf_r;
  assign unf         = unf_r;

  stack_regfile #(
    .WIDTH      (WIDTH),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_regfile (
    .clk   (clk),
    .we    (we_s && clr_n),
    .waddr (waddr_s),
    .wdata (push),
    .raddr (raddr_s),
    .rdata (rdata_s)
  );

  // Next pointers, count, write strobe and error events for this edge.
  always_comb begin
    we_s         = 1'b0;
    waddr_s      = wr_ptr_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    count_nxt_s  = count_r;
    ovf_set_s    = 1'b0;
    unf_set_s    = 1'b0;
    case ({push_en, pop_en})
      2'b10: begin
        if (full_s) begin
          ovf_set_s = 1'b1;
        end else begin
          we_s         = 1'b1;
          wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
          count_nxt_s  = count_r + CNT_ONE;
        end
      end
      2'b01: begin
        if (empty_s) begin
          unf_set_s = 1'b1;
        end else if (mode_r == MODE_FIFO) begin
          rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
          count_nxt_s  = count_r - CNT_ONE;
        end else begin
          wr_ptr_nxt_s = top_ptr_s;
          count_nxt_s  = count_r - CNT_ONE;
        end
      end
      2'b11: begin
        // Empty: the push lands, the pop is rejected.
        if (empty_s) begin
          we_s         = 1'b1;
          wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
          count_nxt_s  = CNT_ONE;
          unf_set_s    = 1'b1;
        end else if (mode_r == MODE_FIFO) begin
          we_s         = 1'b1;
          wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
          rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
          we_s    = 1'b1;
          waddr_s = top_ptr_s;
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Control state; mode may only switch while empty and not being pushed.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      wr_ptr_r <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r <= {DEPTH_LOG2{1'b0}};
      count_r  <= {CW{1'b0}};
      mode_r   <= MODE_LIFO;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      ovf_r    <= ovf_set_s | (ovf_r & ~err_clr);
      unf_r    <= unf_set_s | (unf_r & ~err_clr);
      if (empty_s && !push_en) begin
        mode_r <= mode;
      end else begin
        mode_r <= mode_r;
      end
    end
  end

endmodule

// File: tb/tb_stack_queue.sv
// Self-checking bench for stack_queue (WIDTH=8, depth 4) using a queue-based
// reference model and an expectation scoreboard.
module tb_stack_queue;

  logic       clk = 1'b0;
  logic       clr_n, mode, push_en, pop_en, err_clr;
  logic [7:0] push, peek;
  logic [2:0] count;
  logic       full, not_empty, active_mode, ovf, unf;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       c;
    logic       m;
    logic       p;
    logic       q;
    logic       e;
    logic [7:0] d;
  } stim_t;

  logic [7:0]  mq[$];
  logic        m_mode, m_ovf, m_unf;
  logic [15:0] exp_q[$];

  stack_queue #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
    .clk(clk), .clr_n(clr_n), .mode(mode), .push_en(push_en), .pop_en(pop_en),
    .push(push), .err_clr(err_clr), .peek(peek), .count(count), .full(full),
    .not_empty(not_empty), .active_mode(active_mode), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  function automatic stim_t mk(input logic c, input logic m, input logic p,
                               input logic q, input logic e, input logic [7:0] d);
    stim_t s;
    s.c = c; s.m = m; s.p = p; s.q = q; s.e = e; s.d = d;
    return s;
  endfunction

  // Drives one edge, advances the reference model and records the expectation.
  task automatic drive(input stim_t s);
    bit was_empty, oset, uset;
    logic [7:0] epk;
    @(negedge clk);
    clr_n = s.c; mode = s.m; push_en = s.p; pop_en = s.q; err_clr = s.e; push = s.d;
    if (!s.c) begin
      mq.delete();
      m_mode = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      was_empty = (mq.size() == 0);
      oset = 1'b0; uset = 1'b0;
      if (s.p && s.q) begin
        if (was_empty) begin
          mq.push_back(s.d); uset = 1'b1;
        end else if (m_mode) begin
          void'(mq.pop_front()); mq.push_back(s.d);
        end else begin
          mq[mq.size()-1] = s.d;
        end
      end else if (s.p) begin
        if (mq.size() == 4) oset = 1'b1;
        else mq.push_back(s.d);
      end else if (s.q) begin
        if (was_empty) uset = 1'b1;
        else if (m_mode) void'(mq.pop_front());
        else void'(mq.pop_back());
      end
      m_ovf = oset | (m_ovf & ~s.e);
      m_unf = uset | (m_unf & ~s.e);
      if (was_empty && !s.p) m_mode = s.m;
    end
    if (mq.size() == 0) epk = 8'h00;
    else if (m_mode) epk = mq[0];
    else epk = mq[mq.size()-1];
    exp_q.push_back({epk, 3'(mq.size()), mq.size() == 4, mq.size() != 0,
                     m_mode, m_ovf, m_unf});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] e, o;
    drive(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
    o = {peek, count, full, not_empty, active_mode, ovf, unf};
    e = exp_q.pop_front();
    n_cmp++;
    if (o !== e || o !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset: got %h expected %h", o, e);
    end
  endtask

  task automatic run_table(input string name, input stim_t s[$]);
    logic [15:0] e, o;
    foreach (s[i]) begin
      drive(s[i]);
      o = {peek, count, full, not_empty, active_mode, ovf, unf};
      e = exp_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s step %0d: got %h expected %h (peek,count,full,ne,mode,ovf,unf)",
                 name, i, o, e);
      end
    end
  endtask

  task automatic test_lifo_basic();
    stim_t s[$];
    s.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    s.push_back(mk(1, 0, 1, 0, 0, 8'h11));
    s.push_back(mk(1, 0, 1, 0, 0, 8'h22));
    s.push_back(mk(1, 0, 1, 0, 0, 8'h33));
    s.push_back(mk(1, 0, 0, 1, 0, 8'h00));
    run_table("lifo_basic", s);
    n_cmp++;
    if (peek !== 8'h22 || count !== 3'd2) begin
      n_bad++;
      $display("FAIL lifo_pop_value: got peek=%h count=%0d expected peek=22 count=2", peek, count);
    end
  endtask

  task automatic test_overflow();
    stim_t s[$];
    s.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    for (int i = 1; i <= 5; i++) s.push_back(mk(1, 0, 1, 0, 0, 8'(8'h11 * i)));
    run_table("overflow", s);
    n_cmp++;
    if (peek !== 8'h44 || count !== 3'd4 || ovf !== 1'b1 || full !== 1'b1) begin
      n_bad++;
      $display("FAIL overflow_state: got peek=%h count=%0d ovf=%b full=%b expected 44/4/1/1",
               peek, count, ovf, full);
    end
    s.delete();
    s.push_back(mk(1, 0, 0, 0, 1, 8'h00));
    run_table("ovf_clear", s);
  endtask

  task automatic test_fifo_wrap();
    stim_t s[$];
    s.push_back(mk(0, 1, 0, 0, 0, 8'h00));
    s.push_back(mk(1, 1, 0, 0, 0, 8'h00));
    s.push_back(mk(1, 1, 1, 0, 0, 8'hA1));
    s.push_back(mk(1, 1, 1, 0, 0, 8'hA2));
    s.push_back(mk(1, 1, 1, 0, 0, 8'hA3));
    s.push_back(mk(1, 1, 0, 1, 0, 8'h00));
    s.push_back(mk(1, 1, 0, 1, 0, 8'h00));
    s.push_back(mk(1, 1, 1, 0, 0, 8'hB1));
    s.push_back(mk(1, 1, 1, 0, 0, 8'hB2));
    s.push_back(mk(1, 1, 1, 0, 0, 8'hB3));
    for (int i = 0; i < 4; i++) s.push_back(mk(1, 1, 0, 1, 0, 8'h00));
    run_table("fifo_wrap", s);
    n_cmp++;
    if (not_empty !== 1'b0 || peek !== 8'h00 || active_mode !== 1'b1) begin
      n_bad++;
      $display("FAIL fifo_drained: got ne=%b peek=%h mode=%b expected 0/00/1",
               not_empty, peek, active_mode);
    end
  endtask

  task automatic test_simultaneous();
    stim_t s[$];
    s.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    s.push_back(mk(1, 0, 1, 0, 0, 8'h11));
    s.push_back(mk(1, 0, 1, 0, 0, 8'h22));
    s.push_back(mk(1, 0, 1, 1, 0, 8'h99));
    s.push_back(mk(1, 0, 0, 1, 0, 8'h00));
    s.push_back(mk(0, 1, 0, 0, 0, 8'h00));
    s.push_back(mk(1, 1, 0, 0, 0, 8'h00));
    for (int i = 0; i < 4; i++) s.push_back(mk(1, 1, 1, 0, 0, 8'(8'hA3 + i)));
    s.push_back(mk(1, 1, 1, 1, 0, 8'hC1));
    for (int i = 0; i < 4; i++) s.push_back(mk(1, 1, 0, 1, 0, 8'h00));
    s.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    s.push_back(mk(1, 0, 1, 1, 0, 8'h77));
    run_table("simultaneous", s);
    n_cmp++;
    if (peek !== 8'h77 || count !== 3'd1 || unf !== 1'b1) begin
      n_bad++;
      $display("FAIL empty_push_pop: got peek=%h count=%0d unf=%b expected 77/1/1", peek, count, unf);
    end
  endtask

  task automatic test_mode_lock();
    stim_t s[$];
    s.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    s.push_back(mk(1, 0, 0, 1, 0, 8'h00));
    s.push_back(mk(1, 0, 1, 0, 0, 8'h11));
    s.push_back(mk(1, 1, 1, 0, 0, 8'h22));
    s.push_back(mk(1, 1, 0, 0, 0, 8'h00));
    s.push_back(mk(1, 1, 0, 1, 0, 8'h00));
    s.push_back(mk(1, 1, 0, 1, 0, 8'h00));
    s.push_back(mk(1, 1, 0, 0, 0, 8'h00));
    run_table("mode_lock", s);
    n_cmp++;
    if (active_mode !== 1'b1 || unf !== 1'b1) begin
      n_bad++;
      $display("FAIL mode_switch: got mode=%b unf=%b expected 1/1", active_mode, unf);
    end
  endtask

  task automatic test_clear_mid();
    stim_t s[$];
    s.push_back(mk(1, 0, 0, 1, 0, 8'h00));
    s.push_back(mk(1, 0, 1, 0, 0, 8'h5A));
    s.push_back(mk(1, 0, 1, 0, 0, 8'h5B));
    s.push_back(mk(1, 0, 1, 0, 0, 8'h5C));
    s.push_back(mk(0, 1, 1, 1, 0, 8'hEE));
    run_table("clear_mid", s);
    n_cmp++;
    if ({peek, count, full, not_empty, active_mode, ovf, unf} !== 16'h0000) begin
      n_bad++;
      $display("FAIL clear_outputs: got peek=%h count=%0d ne=%b mode=%b ovf=%b unf=%b expected all 0",
               peek, count, not_empty, active_mode, ovf, unf);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s[$];
    s.push_back(mk(0, 0, 0, 0, 0, 8'h00));
    for (int i = 0; i < 200; i++) begin
      s.push_back(mk(($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom),
                     1'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom)));
    end
    run_table("back_to_back", s);
  endtask

  initial begin
    clr_n = 1'b0; mode = 1'b0; push_en = 1'b0; pop_en = 1'b0; err_clr = 1'b0; push = 8'h00;
    m_mode = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    test_reset();
    test_lifo_basic();
    test_overflow();
    test_fifo_wrap();
    test_simultaneous();
    test_mode_lock();
    test_clear_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_queue.md
Name: stack_queue

Overview:
- Parametrised successor to the single-mode stack: one register-file buffer that runs as a LIFO stack or a FIFO queue, selected by a mode input.
- Adds an occupancy count, simultaneous push/pop, and sticky overflow/underflow error flags.
- Sits between the control unit and datapath as a general-purpose operand/return-address buffer.

Parameters:
WIDTH, 8, data word width in bits
DEPTH_LOG2, 3, log2 of entry count; depth = 2**DEPTH_LOG2 (minimum 1)

Ports:
clk  input  1  system clock, all state changes on rising edge
clr_n  input  1  synchronous active-low clear
mode  input  1  requested mode: 0 = LIFO, 1 = FIFO
push_en  input  1  push request this cycle
pop_en  input  1  pop request this cycle
push  input  WIDTH  data to push
err_clr  input  1  clears the sticky ovf/unf flags
peek  output  WIDTH  top entry (LIFO) or head entry (FIFO); 0 when empty
count  output  DEPTH_LOG2+1  number of stored entries, 0..depth
full  output  1  count == depth
not_empty  output  1  count != 0
active_mode  output  1  mode currently in force
ovf  output  1  sticky: a push was dropped
unf  output  1  sticky: a pop was rejected

Behaviour:
- Reset (clr_n=0 at posedge; dominates all other inputs, including mid-operation): wr_ptr=0, rd_ptr=0, count=0, active_mode=0, ovf=0, unf=0. Outputs become peek=0, full=0, not_empty=0. Storage contents are not cleared.
- Storage is a circular array of depth entries with wr_ptr and rd_ptr, each DEPTH_LOG2 bits, wrapping modulo depth.
- LIFO top is data[wr_ptr-1]. FIFO head is data[rd_ptr].
- peek is combinational from the current pointers and is forced to 0 when count==0.
- full and not_empty are decoded combinationally from the count register.
- active_mode loads mode only on an edge where count==0 and push_en==0. Otherwise it holds, so mode changes requested while data is stored are ignored.
- Per-edge actions, with push_en=P, pop_en=Q:
  - P only, not full: write data[wr_ptr]<=push; wr_ptr+1; count+1.
  - P only, full: push dropped; ovf<=1; no state change.
  - Q only, not empty: LIFO wr_ptr-1; FIFO rd_ptr+1; count-1.
  - Q only, empty: unf<=1; no state change.
  - P&Q, not empty, LIFO: top replaced, data[wr_ptr-1]<=push; pointers and count unchanged. This also holds when full (no ovf).
  - P&Q, not empty, FIFO: write at wr_ptr and read-advance rd_ptr; both pointers +1; count unchanged. This also holds when full (no ovf).
  - P&Q, empty (either mode): push performed, pop rejected; count=1; unf<=1.
- Latency: a push is visible on peek the cycle after the edge. A pop exposes the next entry the cycle after the edge.
- err_clr=1 clears ovf/unf at the edge. An error event on the same edge wins, so the flag stays 1.
- count never exceeds depth and never underflows. Pointer wrap is silent.

Decomposition:
- Package stack_pkg: constants MODE_LIFO=1'b0 and MODE_FIFO=1'b1; function for the count width (DEPTH_LOG2+1).
- One sub-module, stack_regfile: WIDTH x 2**DEPTH_LOG2 array with one synchronous write port and one combinational read port.
- Pointer, count, flag and mode control stay in stack_queue.

Test Plan:
All cases use WIDTH=8, DEPTH_LOG2=2 (depth 4).
1. Reset, mode=0; push 0x11, 0x22, 0x33 -> count=3, peek=0x33. Pop -> peek=0x22, count=2.
2. LIFO push 0x11..0x44 -> full=1. Push 0x55 -> dropped, ovf=1, peek=0x44, count=4. err_clr -> ovf=0.
3. mode=1 while empty; push 0xA1, 0xA2, 0xA3; pop twice; push 0xB1, 0xB2, 0xB3 (wr_ptr wraps) -> count=4, full=1. Successive pops give peek 0xA3, 0xB1, 0xB2, 0xB3, then not_empty=0, peek=0.
4. Simultaneous push/pop:
   - LIFO count=2, top 0x22, push=0x99 -> count=2, peek=0x99.
   - FIFO full with head 0xA3, push=0xC1 -> count=4, peek=next entry, ovf=0.
   - Empty with push=0x77 -> count=1, peek=0x77, unf=1.
5. Pop when empty -> unf=1, count=0. Set mode=1 while LIFO holds 2 entries -> active_mode stays 0. Pop both, then idle cycle -> active_mode=1.
6. Drive clr_n=0 for one edge with count=3 and push_en=1 -> count=0, not_empty=0, peek=0, ovf=unf=0, active_mode=0.
